// File: rtl/aes_dec_iter_ctrl_if.sv
// Host-side stream and status bundle for the iterative AES-128 decryption controller.
// Bit 0 of every 128-bit field is the MSB of byte 0.
interface aes_dec_iter_ctrl_if;
   logic         in_valid;
   logic         in_ready;
   logic [0:127] in_text;
   logic [0:127] in_key;
   logic         key_flush;
   logic         out_valid;
   logic         out_ready;
   logic [0:127] out_text;
   logic         busy;
   logic [3:0]   round_idx;

   modport master (
      output in_valid, in_text, in_key, key_flush, out_ready,
      input  in_ready, out_valid, out_text, busy, round_idx
   );

   modport slave (
      input  in_valid, in_text, in_key, key_flush, out_ready,
      output in_ready, out_valid, out_text, busy, round_idx
   );
endinterface

// File: rtl/aes_dec_iter_ctrl.sv
// Iterative AES-128 decryption: one shared inverse round applied over ten cycles,
// with an 11-slot round-key store that can be reused across blocks under the same key.
module aes_dec_iter_ctrl #(
   parameter bit KEY_CACHE = 1'b1
) (
   input  logic                 clk,
   input  logic                 reset,
   aes_dec_iter_ctrl_if.slave   bus
);

   typedef enum logic [1:0] {IDLE = 2'd0, KEY = 2'd1, ROUND = 2'd2, DONE = 2'd3} state_t;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = 8'h00;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         p  = p ^ (b[i] ? aa : 8'h00);
         aa = xtime(aa);
      end
      return p;
   endfunction

   // Field inverse as a^254 via square-and-multiply; maps 0 to 0 as the S-box needs.
   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] r;
      r = a;
      for (int i = 0; i < 6; i++) begin
         r = gmul(gmul(r, r), a);
      end
      return gmul(r, r);
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] b);
      logic [7:0] x;
      x = gf_inv(b);
      return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]} ^ {x[3:0], x[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [7:0] inv_sbox(input logic [7:0] b);
      return gf_inv({b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05);
   endfunction

   function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
      logic [127:0] o;
      o = 128'h0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+4-r)%4)+r) -: 8];
         end
      end
      return o;
   endfunction

   function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
      logic [127:0] o;
      o = 128'h0;
      for (int i = 0; i < 16; i++) begin
         o[127-8*i -: 8] = inv_sbox(s[127-8*i -: 8]);
      end
      return o;
   endfunction

   function automatic logic [127:0] inv_mix_cols(input logic [127:0] s);
      logic [127:0] o;
      logic [7:0]   a0, a1, a2, a3;
      o = 128'h0;
      for (int c = 0; c < 4; c++) begin
         a0 = s[127-32*c -: 8];
         a1 = s[119-32*c -: 8];
         a2 = s[111-32*c -: 8];
         a3 = s[103-32*c -: 8];
         o[127-32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
         o[119-32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
         o[111-32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
         o[103-32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
      end
      return o;
   endfunction

   // Slot s holds round key s; slot 0 is the cipher key itself.
   function automatic logic [10:0][127:0] key_expand(input logic [127:0] key);
      logic [10:0][127:0] rk;
      logic [31:0]        w0, w1, w2, w3, t;
      logic [7:0]         rc;
      rk               = '0;
      {w0, w1, w2, w3} = key;
      rc               = 8'h01;
      rk[0]            = key;
      for (int r = 1; r <= 10; r++) begin
         t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rc, 24'h000000};
         w0 = w0 ^ t;
         w1 = w1 ^ w0;
         w2 = w2 ^ w1;
         w3 = w3 ^ w2;
         rk[r] = {w0, w1, w2, w3};
         rc = xtime(rc);
      end
      return rk;
   endfunction

   state_t             state_q, state_d;
   logic [127:0]       key_q, key_d, text_q, text_d, st_q, st_d, out_text_q, out_text_d;
   logic [10:0][127:0] sched_q, sched_d, sched_new_s;
   logic               cache_vld_q, cache_vld_d, out_valid_q, out_valid_d;
   logic               busy_q, busy_d, in_ready_q, in_ready_d;
   logic [3:0]         round_q, round_d, rk_sel_s;
   logic [127:0]       in_text_s, in_key_s, inv_rnd_s, rk_s;
   logic               hit_s;

   assign in_text_s   = bus.in_text;
   assign in_key_s    = bus.in_key;
   assign sched_new_s = key_expand(key_q);
   assign inv_rnd_s   = inv_sub_bytes(inv_shift_rows(st_q));
   assign rk_sel_s    = 4'd10 - round_q;
   assign rk_s        = sched_q[rk_sel_s];
   assign hit_s       = KEY_CACHE && cache_vld_q && !bus.key_flush && (in_key_s == key_q);

   assign bus.in_ready  = in_ready_q;
   assign bus.busy      = busy_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_text  = out_text_q;
   assign bus.round_idx = round_q;

   // Next-state, datapath and key-cache decisions
   always_comb begin
      state_d     = state_q;
      key_d       = key_q;
      text_d      = text_q;
      st_d        = st_q;
      sched_d     = sched_q;
      cache_vld_d = cache_vld_q;
      round_d     = round_q;
      out_valid_d = out_valid_q;
      out_text_d  = out_text_q;
      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               if (hit_s) begin
                  st_d    = in_text_s ^ sched_q[10];
                  round_d = 4'd1;
                  state_d = ROUND;
               end else begin
                  key_d       = in_key_s;
                  text_d      = in_text_s;
                  cache_vld_d = 1'b0;
                  state_d     = KEY;
               end
            end else begin
               state_d = IDLE;
            end
         end
         KEY: begin
            sched_d     = sched_new_s;
            st_d        = text_q ^ sched_new_s[10];
            cache_vld_d = 1'b1;
            round_d     = 4'd1;
            state_d     = ROUND;
         end
         ROUND: begin
            if (round_q == 4'd10) begin
               out_text_d  = inv_rnd_s ^ sched_q[0];
               out_valid_d = 1'b1;
               round_d     = 4'd0;
               state_d     = DONE;
            end else begin
               st_d    = inv_mix_cols(inv_rnd_s ^ rk_s);
               round_d = round_q + 4'd1;
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end else begin
               out_valid_d = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      // A flush wins over everything, including the set on the key-setup cycle.
      cache_vld_d = cache_vld_d & ~bus.key_flush;
      busy_d      = (state_d != IDLE);
      in_ready_d  = (state_d == IDLE);
   end

   // Register stage for state, datapath and all outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         key_q       <= 128'h0;
         text_q      <= 128'h0;
         st_q        <= 128'h0;
         sched_q     <= '0;
         cache_vld_q <= 1'b0;
         round_q     <= 4'd0;
         out_valid_q <= 1'b0;
         out_text_q  <= 128'h0;
         busy_q      <= 1'b0;
         in_ready_q  <= 1'b1;
      end else begin
         state_q     <= state_d;
         key_q       <= key_d;
         text_q      <= text_d;
         st_q        <= st_d;
         sched_q     <= sched_d;
         cache_vld_q <= cache_vld_d;
         round_q     <= round_d;
         out_valid_q <= out_valid_d;
         out_text_q  <= out_text_d;
         busy_q      <= busy_d;
         in_ready_q  <= in_ready_d;
      end
   end

endmodule

// File: tb/tb_aes_dec_iter_ctrl.sv
// Bench for aes_dec_iter_ctrl: known-answer vectors driven with random timing, flushes
// and backpressure, checked every cycle against a latency/cache model of the controller.
module tb_aes_dec_iter_ctrl;
   localparam bit KC = 1'b1;

   localparam logic [127:0] VEC_KEY [5] = '{
      128'h000102030405060708090a0b0c0d0e0f,
      128'h2b7e151628aed2a6abf7158809cf4f3c,
      128'h2b7e151628aed2a6abf7158809cf4f3c,
      128'h2b7e151628aed2a6abf7158809cf4f3c,
      128'h00000000000000000000000000000000};
   localparam logic [127:0] VEC_CT [5] = '{
      128'h69c4e0d86a7b0430d8cdb78070b4c55a,
      128'h3925841d02dc09fbdc118597196a0b32,
      128'h3ad77bb40d7a3660a89ecaf32466ef97,
      128'hf5d3d58503b9699de785895a96fdbaaf,
      128'h66e94bd4ef8a2c3b884cfa59ca342b2e};
   localparam logic [127:0] VEC_PT [5] = '{
      128'h00112233445566778899aabbccddeeff,
      128'h3243f6a8885a308d313198a2e0370734,
      128'h6bc1bee22e409f96e93d7e117393172a,
      128'hae2d8a571e03ac9c9eb76fac45af8e51,
      128'h00000000000000000000000000000000};

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   aes_dec_iter_ctrl_if bus();
   aes_dec_iter_ctrl #(.KEY_CACHE(KC)) dut (.clk(clk), .reset(reset), .bus(bus));

   int n_chk  = 0;
   int n_pass = 0;
   int drv_idx = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Reference model: a block in flight is an age since accept plus its fixed latency.
   bit           m_active, m_out_valid, m_cache_vld;
   int           m_age, m_lat;
   logic [127:0] m_pt, m_out_text, m_cache_key;

   always @(posedge clk) begin
      if (reset) begin
         m_active    <= 1'b0;
         m_out_valid <= 1'b0;
         m_out_text  <= 128'h0;
         m_cache_vld <= 1'b0;
         m_cache_key <= 128'h0;
         m_age       <= 0;
         m_lat       <= 0;
      end else if (!m_active) begin
         if (bus.in_valid) begin
            m_active <= 1'b1;
            m_age    <= 0;
            m_pt     <= VEC_PT[drv_idx];
            if (KC && m_cache_vld && !bus.key_flush && bus.in_key == m_cache_key) begin
               m_lat <= 10;
            end else begin
               m_lat       <= 11;
               m_cache_key <= bus.in_key;
               m_cache_vld <= 1'b0;
            end
         end else if (bus.key_flush) begin
            m_cache_vld <= 1'b0;
         end
      end else begin
         m_age <= m_age + 1;
         if (m_lat == 11 && m_age == 0) m_cache_vld <= !bus.key_flush;
         else if (bus.key_flush) m_cache_vld <= 1'b0;
         if (m_age + 1 == m_lat) begin
            m_out_valid <= 1'b1;
            m_out_text  <= m_pt;
         end
         if (m_out_valid && bus.out_ready) begin
            m_out_valid <= 1'b0;
            m_active    <= 1'b0;
         end
      end
   end

   // Per-cycle comparison of every output against the model
   always @(negedge clk) begin
      int         j;
      logic [3:0] er;
      if (chk_en) begin
         er = 4'd0;
         if (m_active && !m_out_valid) begin
            j = m_age - (m_lat - 10);
            if (j >= 0) er = 4'(j + 1);
         end
         chk("in_ready",  128'(bus.in_ready),  128'(!m_active));
         chk("busy",      128'(bus.busy),      128'(m_active));
         chk("out_valid", 128'(bus.out_valid), 128'(m_out_valid));
         chk("out_text",  bus.out_text,        m_out_text);
         chk("round_idx", 128'(bus.round_idx), 128'(er));
      end
   end

   task automatic drive_noise(input bit allow_flush);
      drv_idx       = int'($urandom_range(0, 4));
      bus.in_key    = VEC_KEY[drv_idx];
      bus.in_text   = VEC_CT[drv_idx];
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.key_flush = allow_flush && ($urandom_range(0, 7) == 0);
   endtask

   // Present one block at a negedge in IDLE, wait for the result, hold it, then release.
   task automatic run_block(input int idx, input bit flush_acc, input int hold,
                            input bit noise, input bit noise_flush,
                            output int lat, output logic [127:0] txt, output int rsum);
      int k;
      drv_idx       = idx;
      bus.in_key    = VEC_KEY[idx];
      bus.in_text   = VEC_CT[idx];
      bus.in_valid  = 1'b1;
      bus.key_flush = flush_acc;
      bus.out_ready = 1'b0;
      @(negedge clk);
      bus.in_valid  = 1'b0;
      bus.key_flush = 1'b0;
      k    = 0;
      rsum = 0;
      while (!bus.out_valid && k < 40) begin
         rsum += int'(bus.round_idx);
         if (noise) drive_noise(noise_flush);
         @(negedge clk);
         k++;
      end
      if (k >= 40) begin
         n_chk++;
         $display("FAIL timeout: out_valid not raised within 40 cycles of accept");
      end
      lat = k;
      txt = bus.out_text;
      for (int i = 0; i < hold; i++) begin
         if (noise) drive_noise(noise_flush);
         @(negedge clk);
      end
      bus.in_valid  = 1'b0;
      bus.key_flush = 1'b0;
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
   endtask

   initial begin
      int           lat, rsum, k;
      logic [127:0] txt;
      bus.in_valid  = 1'b0;
      bus.in_text   = 128'h0;
      bus.in_key    = 128'h0;
      bus.key_flush = 1'b0;
      bus.out_ready = 1'b0;
      reset         = 1'b1;
      @(negedge clk);
      chk_en = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("rst_in_ready", 128'(bus.in_ready),  128'd1);
      chk("rst_busy",     128'(bus.busy),      128'd0);
      chk("rst_out_text", bus.out_text,        128'h0);
      reset = 1'b0;
      @(negedge clk);

      // Cold C.1 block, then the same key again from cache
      run_block(0, 1'b0, 0, 1'b0, 1'b0, lat, txt, rsum);
      chk("c1_cold_lat",  128'(lat),  128'd11);
      chk("c1_cold_pt",   txt,        128'h00112233445566778899aabbccddeeff);
      chk("c1_cold_rsum", 128'(rsum), 128'd55);
      run_block(0, 1'b0, 0, 1'b0, 1'b0, lat, txt, rsum);
      chk("c1_hit_lat",   128'(lat),  128'd10);
      chk("c1_hit_pt",    txt,        128'h00112233445566778899aabbccddeeff);
      chk("c1_hit_rsum",  128'(rsum), 128'd55);

      // Key change, then backpressure with in_valid noise under the new cached key
      run_block(1, 1'b0, 0, 1'b0, 1'b0, lat, txt, rsum);
      chk("keychg_lat", 128'(lat), 128'd11);
      chk("keychg_pt",  txt,       128'h3243f6a8885a308d313198a2e0370734);
      run_block(2, 1'b0, 5, 1'b1, 1'b0, lat, txt, rsum);
      chk("bp_lat", 128'(lat), 128'd10);
      chk("bp_pt",  txt,       128'h6bc1bee22e409f96e93d7e117393172a);

      // Flush on the accept edge forces key setup despite a matching key
      run_block(3, 1'b1, 0, 1'b0, 1'b0, lat, txt, rsum);
      chk("flush_lat", 128'(lat), 128'd11);
      chk("flush_pt",  txt,       128'hae2d8a571e03ac9c9eb76fac45af8e51);
      run_block(3, 1'b0, 0, 1'b0, 1'b0, lat, txt, rsum);
      chk("after_flush_lat", 128'(lat), 128'd10);

      // Reset in the middle of round 5
      drv_idx      = 1;
      bus.in_key   = VEC_KEY[1];
      bus.in_text  = VEC_CT[1];
      bus.in_valid = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0;
      k = 0;
      while (bus.round_idx != 4'd5 && k < 20) begin
         @(negedge clk);
         k++;
      end
      if (k >= 20) begin
         n_chk++;
         $display("FAIL timeout: round_idx never reached 5");
      end
      reset = 1'b1;
      @(negedge clk);
      chk("midrst_busy",      128'(bus.busy),      128'd0);
      chk("midrst_out_valid", 128'(bus.out_valid), 128'd0);
      chk("midrst_round",     128'(bus.round_idx), 128'd0);
      chk("midrst_out_text",  bus.out_text,        128'h0);
      reset = 1'b0;
      @(negedge clk);
      run_block(1, 1'b0, 0, 1'b0, 1'b0, lat, txt, rsum);
      chk("post_rst_lat", 128'(lat), 128'd11);
      chk("post_rst_pt",  txt,       128'h3243f6a8885a308d313198a2e0370734);

      // Randomized traffic: vectors, gaps, flushes, noise and backpressure
      for (int n = 0; n < 40; n++) begin
         int idx, gap;
         idx = int'($urandom_range(0, 4));
         gap = int'($urandom_range(0, 3));
         for (int g = 0; g < gap; g++) begin
            bus.key_flush = ($urandom_range(0, 3) == 0);
            @(negedge clk);
         end
         run_block(idx, ($urandom_range(0, 5) == 0), int'($urandom_range(0, 4)),
                   1'b1, 1'b1, lat, txt, rsum);
         chk("rand_pt", txt, VEC_PT[idx]);
      end

      @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/aes_dec_iter_ctrl.md
Name: aes_dec_iter_ctrl

Overview:
- Iterative AES-128 decryption controller. It sequences one shared round datapath (inv_shift_row -> inv_sub_byte -> add_round_key -> mix_col_cp) over 10 rounds, instead of instantiating 10 unrolled rounds.
- It owns the 11-slot round-key store, filled from inv_key_gen. It can cache the last key so back-to-back blocks under the same key skip key setup.
- It sits between the host-side valid/ready stream and the AES core primitives. Output is registered and held until the consumer accepts it.

Parameters:
- KEY_CACHE, 1, 1 = reuse the stored schedule when in_key equals the cached key; 0 = run key setup for every block.

Ports:
- clk  in  1  system clock, all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  a block and its key are presented.
- in_ready  out  1  controller can accept a block (high only in IDLE).
- in_text  in  [0:127]  ciphertext, bit 0 = MSB of byte 0.
- in_key  in  [0:127]  cipher key, same bit order.
- key_flush  in  1  invalidates the key cache; evaluated every cycle.
- out_valid  out  1  out_text holds a valid plaintext.
- out_ready  in  1  consumer accepts out_text.
- out_text  out  [0:127]  registered plaintext.
- busy  out  1  high in any state other than IDLE.
- round_idx  out  4  current round number, 0..10; 0 outside ROUND.

Behaviour:
- Reset (synchronous, any state, including mid-round):
  - state = IDLE.
  - out_valid = 0, out_text = 0, round_idx = 0, busy = 0.
  - cache_vld = 0; key and schedule registers cleared to 0.
- Key store: slot s = bits [128*s : 128*s+127] of the inv_key_gen output, driven from the registered key.
  - The initial AddRoundKey uses slot 10.
  - Round r (1..10) uses slot 10-r.
- States: IDLE, KEY, ROUND, DONE.
- IDLE, in_ready = 1. On in_valid:
  - Hit = KEY_CACHE && cache_vld && !key_flush && in_key == cached key.
    - On hit: st <= in_text ^ slot10; round_idx <= 1; go to ROUND.
  - Miss: key_reg <= in_key; text_reg <= in_text; cache_vld <= 0; go to KEY.
- KEY (1 cycle):
  - Latch all 11 slots from inv_key_gen(key_reg).
  - st <= text_reg ^ new slot10.
  - cache_vld <= 1, unless key_flush is high this cycle.
  - round_idx <= 1; go to ROUND.
- ROUND, one round per cycle:
  - r = 1..9: st <= mix_col_cp(inv_sub_byte(inv_shift_row(st)) ^ slot[10-r]); round_idx <= r+1.
  - r = 10: out_text <= inv_sub_byte(inv_shift_row(st)) ^ slot0; out_valid <= 1; round_idx <= 0; go to DONE.
- DONE:
  - out_valid and out_text are held stable while out_ready is low.
  - On out_ready: out_valid <= 0; go to IDLE. A new block can be accepted the following cycle.
- Latency, counted from the accept edge:
  - Hit: 10 edges until out_valid rises.
  - Miss: 11 edges until out_valid rises.
  - Best-case throughput: one block per 12 cycles on a hit.
- Handshake rules:
  - in_text and in_key are sampled only on the accept edge.
  - Input changes while busy are ignored.
  - in_ready is low in KEY, ROUND and DONE.
- key_flush:
  - In any state, clears cache_vld.
  - Never aborts a block in flight; that block completes with the schedule already latched.
- With KEY_CACHE = 0, every block takes the miss path.

Test Plan:
- FIPS-197 C.1, cold (miss): key 000102030405060708090a0b0c0d0e0f, ct 69c4e0d86a7b0430d8cdb78070b4c55a -> out_text 00112233445566778899aabbccddeeff; out_valid rises 11 edges after accept; round_idx steps 1..10.
- Same key, second block (hit): ct 69c4e0d86a7b0430d8cdb78070b4c55a -> same plaintext after 10 edges; KEY state never entered.
- Key change: key 2b7e151628aed2a6abf7158809cf4f3c, ct 3925841d02dc09fbdc118597196a0b32 -> 3243f6a8885a308d313198a2e0370734 after 11 edges (miss).
- Backpressure: hold out_ready = 0 for 5 cycles in DONE -> out_valid and out_text stable, in_ready = 0, in_valid pulses ignored; out_ready = 1 -> IDLE next cycle.
- key_flush asserted with a matching key on the accept edge -> miss path (11 edges), correct plaintext.
- Reset asserted at round_idx = 5 -> next cycle IDLE, out_valid = 0, out_text = 0, round_idx = 0, busy = 0; next block with the previous key takes the miss path.
